rdma_meta_tx_arbiter: RTL and testbench

//   Transmit-side counterpart of the RDMA RX meta demux. Merges per-region RDMA request meta

---
 rtl/rdma_meta_tx_arbiter_pkg.sv | 24 ++
 rtl/rdma_meta_tx_arbiter_arb.sv | 41 ++++
 rtl/rdma_meta_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_rdma_meta_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_meta_tx_arbiter_pkg.sv
// Shared types for the RDMA TX meta path: region count, request meta layout,
// and the round-robin pointer advance used by the arbiter top.
package rdma_meta_tx_arbiter_pkg;

   localparam int unsigned N_REGIONS      = 4;
   // Fixed width so that out-of-range completion ids stay representable.
   localparam int unsigned N_REGIONS_BITS = 4;

   typedef struct packed {
      logic [4:0]                opcode;
      logic [9:0]                qpn;
      logic [N_REGIONS_BITS-1:0] vfid;
      logic                      host;
      logic [31:0]               vaddr;
      logic [15:0]               len;
   } req_t;

   localparam int unsigned REQ_BITS = $bits(req_t);

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rdma_meta_tx_arbiter_arb.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping
// to index 0; works for any N, not only powers of two.
module meta_rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   input  logic          en,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic          hi_vld;
   logic          lo_vld;
   logic [PW-1:0] hi_idx;
   logic [PW-1:0] lo_idx;

   // lo_* finds the lowest requester overall (the wrap case), hi_* the lowest one at or above rr_ptr.
   always_comb begin
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) begin
            if (!lo_vld) begin
               lo_vld = 1'b1;
               lo_idx = PW'(i);
            end
            if (!hi_vld && (PW'(i) >= rr_ptr)) begin
               hi_vld = 1'b1;
               hi_idx = PW'(i);
            end
         end
      end
      gnt_vld = en & (hi_vld | lo_vld);
      gnt_idx = hi_vld ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/rdma_meta_tx_arbiter.sv
// Merges per-region RDMA request meta into one registered stream, round-robin,
// stamping the source region into vfid and limiting in-flight requests per region.
module rdma_meta_tx_arbiter
   import rdma_meta_tx_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 16
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [N_REGIONS-1:0]          s_meta_user_valid,
   output logic [N_REGIONS-1:0]          s_meta_user_ready,
   input  logic [N_REGIONS*REQ_BITS-1:0] s_meta_user_data,
   output logic                          m_meta_valid,
   input  logic                          m_meta_ready,
   output logic [REQ_BITS-1:0]           m_meta_data,
   input  logic                          cpl_valid,
   input  logic [N_REGIONS_BITS-1:0]     cpl_vfid,
   output logic [N_REGIONS_BITS-1:0]     vfid,
   output logic                          cpl_err
);

   localparam int unsigned PW    = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
   localparam int unsigned CNT_W = (MAX_OUTSTANDING == 0) ? 16 : $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        gnt_idx;
   logic                 gnt_vld;
   logic                 load;
   logic [N_REGIONS-1:0] eligible;
   logic [N_REGIONS-1:0] inc_vec;
   logic [N_REGIONS-1:0] dec_vec;
   logic                 err_set;
   req_t                 user_req [N_REGIONS];
   req_t                 sel_req;
   req_t                 out_req;
   logic [CNT_W-1:0]     outstanding     [N_REGIONS];
   logic [CNT_W-1:0]     outstanding_nxt [N_REGIONS];

   assign load        = !m_meta_valid | m_meta_ready;
   assign m_meta_data = out_req;

   always_comb begin
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         user_req[i] = req_t'(s_meta_user_data[i*REQ_BITS +: REQ_BITS]);
         eligible[i] = s_meta_user_valid[i] &&
                       ((MAX_OUTSTANDING == 0) || (outstanding[i] < CNT_MAX));
      end
   end

   meta_rr_arbiter #(
      .N (N_REGIONS)
   ) u_arb (
      .req     (eligible),
      .rr_ptr  (rr_ptr),
      .en      (load & ~areset),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      s_meta_user_ready = '0;
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         s_meta_user_ready[i] = gnt_vld && (gnt_idx == PW'(i));
      end
      sel_req      = user_req[gnt_idx];
      sel_req.vfid = N_REGIONS_BITS'(gnt_idx);
   end

   generate
      if (N_REGIONS > 1) begin : g_rr
         always_ff @(posedge aclk) begin
            if (areset) begin
               rr_ptr <= '0;
            end else if (gnt_vld) begin
               rr_ptr <= PW'(rr_next(32'(gnt_idx), N_REGIONS));
            end
         end
      end else begin : g_no_rr
         assign rr_ptr = '0;
      end
   endgenerate

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_meta_valid <= 1'b0;
         out_req      <= '0;
         vfid         <= '0;
      end else if (load) begin
         m_meta_valid <= gnt_vld;
         if (gnt_vld) begin
            out_req <= sel_req;
            vfid    <= N_REGIONS_BITS'(gnt_idx);
         end
      end
   end

   // A completion that lands in the same cycle as an accept cancels it out.
   always_comb begin
      err_set = cpl_valid && (32'(cpl_vfid) >= N_REGIONS);
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         inc_vec[i]         = gnt_vld && (gnt_idx == PW'(i));
         dec_vec[i]         = cpl_valid && (32'(cpl_vfid) == i);
         outstanding_nxt[i] = outstanding[i];
         if (inc_vec[i] && !dec_vec[i]) begin
            outstanding_nxt[i] = outstanding[i] + CNT_W'(1);
         end else if (dec_vec[i] && !inc_vec[i]) begin
            if (outstanding[i] == '0) begin
               err_set = 1'b1;
            end else begin
               outstanding_nxt[i] = outstanding[i] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int unsigned i = 0; i < N_REGIONS; i++) begin
            outstanding[i] <= '0;
         end
         cpl_err <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_REGIONS; i++) begin
            outstanding[i] <= outstanding_nxt[i];
         end
         if (err_set) begin
            cpl_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rdma_meta_tx_arbiter.sv
// Directed bench for rdma_meta_tx_arbiter with four regions and a limit of two
// outstanding requests per region.
module tb_rdma_meta_tx_arbiter;
   import rdma_meta_tx_arbiter_pkg::*;

   logic                          aclk = 1'b0;
   logic                          areset;
   logic [N_REGIONS-1:0]          s_valid;
   logic [N_REGIONS-1:0]          s_ready;
   logic [N_REGIONS*REQ_BITS-1:0] s_data;
   logic                          m_valid;
   logic                          m_ready;
   logic [REQ_BITS-1:0]           m_data;
   logic                          cpl_valid;
   logic [N_REGIONS_BITS-1:0]     cpl_vfid;
   logic [N_REGIONS_BITS-1:0]     vfid;
   logic                          cpl_err;

   req_t        user_req [N_REGIONS];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned beats    = 0;

   always #5 aclk = ~aclk;

   assign s_data = {user_req[3], user_req[2], user_req[1], user_req[0]};

   always @(posedge aclk) if (m_valid && m_ready) beats++;

   rdma_meta_tx_arbiter #(
      .MAX_OUTSTANDING (2)
   ) dut (
      .aclk              (aclk),
      .areset            (areset),
      .s_meta_user_valid (s_valid),
      .s_meta_user_ready (s_ready),
      .s_meta_user_data  (s_data),
      .m_meta_valid      (m_valid),
      .m_meta_ready      (m_ready),
      .m_meta_data       (m_data),
      .cpl_valid         (cpl_valid),
      .cpl_vfid          (cpl_vfid),
      .vfid              (vfid),
      .cpl_err           (cpl_err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic complete(input logic [N_REGIONS_BITS-1:0] r);
      cpl_valid = 1'b1;
      cpl_vfid  = r;
      step();
      cpl_valid = 1'b0;
   endtask

   function automatic req_t mk_req(input int unsigned r, input int unsigned seq,
                                   input logic [3:0] uvf);
      req_t q;
      q.opcode = 5'(r + 1);
      q.qpn    = 10'(seq * 7 + r);
      q.vfid   = uvf;
      q.host   = seq[0];
      q.vaddr  = 32'h1000_0000 + 32'(r << 12) + 32'(seq);
      q.len    = 16'(64 * (seq + 1));
      return q;
   endfunction

   function automatic req_t stamp(input req_t q, input int unsigned r);
      q.vfid = 4'(r);
      return q;
   endfunction

   initial begin
      int unsigned r;
      int unsigned beats0;
      req_t        exp_q;
      req_t        exp_q2;

      for (int unsigned i = 0; i < N_REGIONS; i++) user_req[i] = mk_req(i, 0, 4'hC);
      areset    = 1'b1;
      s_valid   = 4'hF;
      m_ready   = 1'b1;
      cpl_valid = 1'b0;
      cpl_vfid  = '0;
      step();
      step();
      check("rst_valid", m_valid, 0);
      check("rst_vfid",  vfid,    0);
      check("rst_err",   cpl_err, 0);
      check("rst_ready", s_ready, 0);
      areset = 1'b0;

      // Test 1: all regions valid, two credits each
      for (int unsigned k = 0; k < 8; k++) begin
         r = k % 4;
         settle();
         check("t1_ready", s_ready, 4'b0001 << r);
         exp_q = stamp(user_req[r], r);
         step();
         check("t1_valid", m_valid, 1);
         check("t1_vfid",  vfid,    r);
         check("t1_data",  m_data,  exp_q);
         user_req[r] = mk_req(r, k + 1, 4'hC);
      end
      settle();
      check("t1_ready_off", s_ready, 0);
      step();
      check("t1_drained", m_valid, 0);
      s_valid = '0;
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         complete(4'(i));
         complete(4'(i));
      end

      // Test 2: single region, credit limit and completion release
      s_valid     = 4'b0100;
      user_req[2] = mk_req(2, 20, 4'd3);
      for (int unsigned j = 0; j < 2; j++) begin
         settle();
         check("t2_ready", s_ready, 4'b0100);
         exp_q = stamp(user_req[2], 2);
         step();
         check("t2_vfid", vfid,   2);
         check("t2_data", m_data, exp_q);
         user_req[2] = mk_req(2, 21 + j, 4'd3);
      end
      settle();
      check("t2_blocked", s_ready, 0);
      step();
      check("t2_empty", m_valid, 0);
      cpl_valid = 1'b1;
      cpl_vfid  = 4'd2;
      settle();
      check("t2_no_bypass", s_ready, 0);
      exp_q = stamp(user_req[2], 2);
      step();
      cpl_valid = 1'b0;
      settle();
      check("t2_released", s_ready, 4'b0100);
      step();
      check("t2_valid3", m_valid, 1);
      check("t2_data3",  m_data,  exp_q);
      s_valid = '0;
      complete(4'd2);
      complete(4'd2);

      // Test 3: output backpressure for five cycles
      beats0      = beats;
      s_valid     = 4'b0010;
      m_ready     = 1'b0;
      user_req[1] = mk_req(1, 30, 4'hC);
      settle();
      check("t3_ready_load", s_ready, 4'b0010);
      exp_q = stamp(user_req[1], 1);
      step();
      user_req[1] = mk_req(1, 31, 4'hC);
      for (int unsigned s = 0; s < 5; s++) begin
         settle();
         check("t3_hold_valid", m_valid, 1);
         check("t3_hold_vfid",  vfid,    1);
         check("t3_hold_data",  m_data,  exp_q);
         check("t3_hold_ready", s_ready, 0);
         step();
      end
      m_ready = 1'b1;
      settle();
      check("t3_ready_back", s_ready, 4'b0010);
      exp_q2 = stamp(user_req[1], 1);
      step();
      s_valid = '0;
      check("t3_next_data", m_data, exp_q2);
      step();
      check("t3_empty", m_valid, 0);
      check("t3_beats", beats - beats0, 2);
      complete(4'd1);
      complete(4'd1);

      // Test 4: wrap from region 3 to 0, then same-cycle accept and completion
      s_valid = 4'b0100;
      settle();
      step();
      s_valid = '0;
      complete(4'd2);
      s_valid = 4'b1001;
      settle();
      check("t4_first", s_ready, 4'b1000);
      step();
      check("t4_vfid3", vfid, 3);
      settle();
      check("t4_wrap", s_ready, 4'b0001);
      step();
      check("t4_vfid0", vfid, 0);
      s_valid   = 4'b0001;
      cpl_valid = 1'b1;
      cpl_vfid  = 4'd0;
      settle();
      check("t4_same_ready", s_ready, 4'b0001);
      step();
      cpl_valid = 1'b0;
      settle();
      check("t4_cnt_room", s_ready, 4'b0001);
      step();
      settle();
      check("t4_cnt_full", s_ready, 0);
      s_valid = '0;
      complete(4'd0);
      complete(4'd0);
      complete(4'd3);

      // Test 5: completion underflow, then out-of-range completion id
      check("t5_err_clear", cpl_err, 0);
      complete(4'd1);
      check("t5_err_underflow", cpl_err, 1);
      s_valid = 4'b0010;
      settle();
      check("t5_ready_a", s_ready, 4'b0010);
      step();
      settle();
      check("t5_ready_b", s_ready, 4'b0010);
      step();
      settle();
      check("t5_cnt_full", s_ready, 0);
      s_valid = '0;
      complete(4'd5);
      check("t5_err_sticky", cpl_err, 1);
      s_valid = 4'b0010;
      settle();
      check("t5_oor_ignored", s_ready, 0);
      s_valid = '0;

      // Test 6: reset while a beat is stalled on the output
      m_ready = 1'b0;
      s_valid = 4'b0100;
      settle();
      step();
      check("t6_stalled", m_valid, 1);
      check("t6_vfid2",   vfid,    2);
      areset = 1'b1;
      step();
      check("t6_valid_clr", m_valid, 0);
      check("t6_vfid_clr",  vfid,    0);
      check("t6_err_clr",   cpl_err, 0);
      areset  = 1'b0;
      m_ready = 1'b1;
      s_valid = 4'hF;
      settle();
      check("t6_first_grant", s_ready, 4'b0001);
      step();
      check("t6_first_vfid", vfid, 0);
      s_valid = 4'b0010;
      settle();
      check("t6_cnt_cleared", s_ready, 4'b0010);
      s_valid = '0;
      step();
      complete(4'd5);
      check("t6_oor_err", cpl_err, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
